// File: rtl/tbd_pkg.sv
// Shared types and defaults for the tbd accelerator result writer.
//   wr_state_t  : writer FSM states
//   wr_entry_t  : one queued SRAM write (word address, packed data, byte enables)
//   TBD_*       : default widths, base addresses and queue depth
package tbd_pkg;

   localparam int                    TBD_ADDR_W     = 10;
   localparam logic [TBD_ADDR_W-1:0] TBD_OUT_BASE   = 10'd256;
   localparam int                    TBD_FIFO_DEPTH = 4;
   // MMIO base of the accelerator; decoding happens upstream of this block.
   localparam logic [31:0]           TBD_BASE_ADDR  = 32'h2000_0000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PACK  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } wr_state_t;

   typedef struct packed {
      logic [TBD_ADDR_W-1:0] addr;
      logic [31:0]           wdata;
      logic [3:0]            be;
   } wr_entry_t;

endpackage

// File: rtl/tbd_wr_fifo.sv
// Synchronous write queue of wr_entry_t.
//   clk, rst_n  : clock, synchronous active-low reset (empties the queue)
//   push        : enqueue push_data (ignored when full)
//   push_data   : entry to enqueue
//   pop         : dequeue the head (ignored when empty)
//   full, empty : occupancy flags
//   head        : oldest entry; only meaningful while !empty
// Pointers carry one extra wrap bit so full and empty are told apart without
// a separate counter.
module tbd_wr_fifo
   import tbd_pkg::*;
#(
   parameter int DEPTH = TBD_FIFO_DEPTH
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  wr_entry_t push_data,
   input  logic      pop,
   output logic      full,
   output logic      empty,
   output wr_entry_t head
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
   wr_entry_t      mem_q [DEPTH];
   wr_entry_t      mem_d [DEPTH];
   logic           do_push;
   logic           do_pop;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
         wr_ptr_d                   = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/tbd_result_writer.sv
// Result writer: packs a stream of 8-bit results four per 32-bit word
// (little-endian) and writes them to SRAM bank 0 from OUT_BASE upward.
//   clk, rst_n                 : clock, synchronous active-low reset
//   start, num_pix             : MMIO job start and byte count (sampled in IDLE/DONE)
//   busy, done                 : MMIO status; done is sticky until the next start
//   pix_valid/pix_ready/pix_data : result byte stream
//   sram_req/we/addr/wdata/be  : SRAM write request, held stable until sram_gnt
//   sram_gnt                   : SRAM accepted the current request
//   dbg_state                  : current FSM state, for observation only
//
// Handshakes: a byte moves when pix_valid && pix_ready at a rising edge; an
// SRAM word moves when sram_req && sram_gnt at a rising edge. Neither ready
// nor req depends combinationally on its partner's valid/gnt.
module tbd_result_writer
   import tbd_pkg::*;
#(
   parameter logic [TBD_ADDR_W-1:0] OUT_BASE   = TBD_OUT_BASE,
   parameter int                    FIFO_DEPTH = TBD_FIFO_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [TBD_ADDR_W-1:0] num_pix,
   output logic                  busy,
   output logic                  done,
   input  logic                  pix_valid,
   output logic                  pix_ready,
   input  logic [7:0]            pix_data,
   output logic                  sram_req,
   output logic                  sram_we,
   output logic [TBD_ADDR_W-1:0] sram_addr,
   output logic [31:0]           sram_wdata,
   output logic [3:0]            sram_be,
   input  logic                  sram_gnt,
   output wr_state_t             dbg_state
);

   wr_state_t             state_q, state_d;
   logic [TBD_ADDR_W-1:0] num_pix_q, num_pix_d;
   logic [TBD_ADDR_W-1:0] byte_cnt_q, byte_cnt_d;
   logic [TBD_ADDR_W-1:0] word_idx_q, word_idx_d;
   logic [31:0]           pack_data_q, pack_data_d;
   logic [3:0]            pack_be_q, pack_be_d;

   logic                  fifo_push;
   wr_entry_t             fifo_push_data;
   logic                  fifo_full;
   logic                  fifo_empty;
   wr_entry_t             fifo_head;

   logic                  accept;
   logic [1:0]            lane;
   logic [TBD_ADDR_W:0]   cnt_next;
   logic                  last_byte;
   logic [31:0]           merged_data;
   logic [3:0]            merged_be;

   tbd_wr_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (fifo_push_data),
      .pop       (sram_gnt),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

   assign pix_ready = (state_q == PACK) && !fifo_full;
   assign accept    = pix_valid && pix_ready;
   assign busy      = (state_q == PACK) || (state_q == DRAIN);
   assign done      = (state_q == DONE);
   assign dbg_state = state_q;

   // The write side just follows the queue head; the FSM never stalls it.
   assign sram_req   = !fifo_empty;
   assign sram_we    = sram_req;
   assign sram_addr  = sram_req ? fifo_head.addr  : '0;
   assign sram_wdata = sram_req ? fifo_head.wdata : '0;
   assign sram_be    = sram_req ? fifo_head.be    : '0;

   assign lane      = byte_cnt_q[1:0];
   assign cnt_next  = {1'b0, byte_cnt_q} + 1'b1;
   assign last_byte = (cnt_next == {1'b0, num_pix_q});

   always_comb begin
      merged_data                     = pack_data_q;
      merged_data[{lane, 3'b000} +: 8] = pix_data;
      merged_be                       = pack_be_q | (4'b0001 << lane);
   end

   always_comb begin
      state_d        = state_q;
      num_pix_d      = num_pix_q;
      byte_cnt_d     = byte_cnt_q;
      word_idx_d     = word_idx_q;
      pack_data_d    = pack_data_q;
      pack_be_d      = pack_be_q;
      fifo_push      = 1'b0;
      fifo_push_data = '0;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               num_pix_d   = num_pix;
               byte_cnt_d  = '0;
               word_idx_d  = '0;
               pack_data_d = '0;
               pack_be_d   = '0;
               // An empty job passes through DRAIN (queue already empty) so it
               // never opens pix_ready and reports done one cycle later.
               state_d     = (num_pix == '0) ? DRAIN : PACK;
            end
         end
         PACK: begin
            if (accept) begin
               byte_cnt_d = cnt_next[TBD_ADDR_W-1:0];
               if ((lane == 2'd3) || last_byte) begin
                  // pix_ready already guaranteed a free slot for this push.
                  fifo_push            = 1'b1;
                  fifo_push_data.addr  = OUT_BASE + word_idx_q;
                  fifo_push_data.wdata = merged_data;
                  fifo_push_data.be    = merged_be;
                  word_idx_d           = word_idx_q + 1'b1;
                  pack_data_d          = '0;
                  pack_be_d            = '0;
               end else begin
                  pack_data_d = merged_data;
                  pack_be_d   = merged_be;
               end
               if (last_byte) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (fifo_empty) begin
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         num_pix_q   <= '0;
         byte_cnt_q  <= '0;
         word_idx_q  <= '0;
         pack_data_q <= '0;
         pack_be_q   <= '0;
      end else begin
         state_q     <= state_d;
         num_pix_q   <= num_pix_d;
         byte_cnt_q  <= byte_cnt_d;
         word_idx_q  <= word_idx_d;
         pack_data_q <= pack_data_d;
         pack_be_q   <= pack_be_d;
      end
   end

endmodule
